// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one combinational ALU between two requesters. Each requester hands over {a, b, op}
//   on a valid/ready handshake and receives the result on a resp valid/ready handshake. Only one
//   operation is in flight at a time. Arbitration is round-robin or fixed priority (requester 0).
//   Each operation takes at least three cycles: accept, sample ALU, respond.
//
// Ports
//   clk, rst_n              clock; synchronous active-low reset
//   req_valid/req_ready     per-requester command handshake (bit i = requester i)
//   req_a/req_b/req_op      packed commands, requester i at [i*W +: W] / [i*OPW +: OPW]
//   resp_valid/resp_ready   per-requester result handshake
//   resp_data               shared result bus, meaningful for the bit set in resp_valid
//   alu_a/alu_b/alu_op      registered operands driven to the external ALU
//   alu_res                 ALU result, combinational from alu_a/alu_b/alu_op
//   last_res                most recent completed result (display path)
//   op_count                completed operation count, wraps modulo 256
module alu_req_arbiter #(
  parameter int unsigned W          = 4,
  parameter int unsigned OPW        = 3,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic [0:0]       clk,
  input  logic [0:0]       rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*W-1:0]   req_a,
  input  logic [2*W-1:0]   req_b,
  input  logic [2*OPW-1:0] req_op,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [W-1:0]     resp_data,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [W-1:0]     alu_res,
  output logic [W-1:0]     last_res,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           rr_ptr_q, rr_ptr_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic [W-1:0]   resp_data_q, resp_data_d;
  logic [W-1:0]   last_res_q, last_res_d;
  logic [7:0]     op_count_q, op_count_d;

  logic grant_any;
  logic grant_idx;

  // Winner among the valid requesters; only meaningful when grant_any is set.
  always_comb begin
    grant_idx = 1'b0;
    if (FIXED_PRIO != 0) begin
      grant_idx = ~req_valid[0];
    end else if (&req_valid) begin
      grant_idx = rr_ptr_q;
    end else begin
      grant_idx = req_valid[1];
    end
  end

  assign grant_any = |req_valid;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    resp_data_d = resp_data_q;
    last_res_d  = last_res_q;
    op_count_d  = op_count_q;
    req_ready   = 2'b00;
    resp_valid  = 2'b00;

    unique case (state_q)
      StIdle: begin
        // Handshakes are suppressed while reset is asserted.
        if (rst_n[0] && grant_any) begin
          req_ready[grant_idx] = 1'b1;
          owner_d              = grant_idx;
          rr_ptr_d             = ~grant_idx;
          alu_a_d              = grant_idx ? req_a[2*W-1:W]     : req_a[W-1:0];
          alu_b_d              = grant_idx ? req_b[2*W-1:W]     : req_b[W-1:0];
          alu_op_d             = grant_idx ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
          state_d              = StIssue;
        end
      end
      StIssue: begin
        // Operands have been stable for a full cycle; capture the ALU output.
        resp_data_d = alu_res;
        last_res_d  = alu_res;
        op_count_d  = op_count_q + 8'd1;
        state_d     = StResp;
      end
      StResp: begin
        if (rst_n[0]) begin
          resp_valid[owner_q] = 1'b1;
          if (resp_ready[owner_q]) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n[0]) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      resp_data_q <= '0;
      last_res_q  <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      resp_data_q <= resp_data_d;
      last_res_q  <= last_res_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign resp_data = resp_data_q;
  assign last_res  = last_res_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a round-robin instance checked every cycle against a
// transaction-level model, plus a fixed-priority instance sharing the same stimulus.
module tb_alu_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [5:0] req_op;
  logic [1:0] resp_ready;

  logic [1:0] req_ready, resp_valid;
  logic [3:0] resp_data, alu_a, alu_b, alu_res, last_res;
  logic [2:0] alu_op;
  logic [7:0] op_count;

  logic [1:0] f_req_ready, f_resp_valid;
  logic [3:0] f_resp_data, f_alu_a, f_alu_b, f_alu_res, f_last_res;
  logic [2:0] f_alu_op;
  logic [7:0] f_op_count;

  int n_pass = 0;
  int n_tot  = 0;

  // Behavioural ALU: the environment the arbiter drives, and the result reference.
  function automatic logic [3:0] alu_f(logic [3:0] a, logic [3:0] b, logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return ~a;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return 4'd0;
      default: return (a == b) ? 4'd1 : 4'd0;
    endcase
  endfunction

  assign alu_res   = alu_f(alu_a, alu_b, alu_op);
  assign f_alu_res = alu_f(f_alu_a, f_alu_b, f_alu_op);

  alu_req_arbiter #(.W(4), .OPW(3), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_res(alu_res), .last_res(last_res), .op_count(op_count)
  );

  alu_req_arbiter #(.W(4), .OPW(3), .FIXED_PRIO(1)) u_fx (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(f_req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .resp_valid(f_resp_valid),
    .resp_ready(resp_ready), .resp_data(f_resp_data), .alu_a(f_alu_a), .alu_b(f_alu_b),
    .alu_op(f_alu_op), .alu_res(f_alu_res), .last_res(f_last_res), .op_count(f_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Transaction model of the round-robin instance.
  int         m_phase;  // 0 waiting for a command, 1 ALU busy, 2 result offered
  int         m_ptr;
  int         m_owner;
  bit         m_known;
  logic [3:0] m_a, m_b, m_res, m_last, m_pend;
  logic [2:0] m_op;
  logic [7:0] m_cnt;
  logic [1:0] acc;      // requester whose command was taken at the last edge

  function automatic int winner(logic [1:0] v, int ptr);
    if (v == 2'b00) return -1;
    if (v == 2'b11) return ptr;
    return v[0] ? 0 : 1;
  endfunction

  task automatic set_cmd(int i, logic [3:0] a, logic [3:0] b, logic [2:0] op);
    req_a[i*4 +: 4]  = a;
    req_b[i*4 +: 4]  = b;
    req_op[i*3 +: 3] = op;
    req_valid[i]     = 1'b1;
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next one.
  task automatic tick();
    int         w;
    logic [1:0] er, ev;
    #1;
    er = 2'b00;
    ev = 2'b00;
    w  = -1;
    if (rst_n && m_phase == 0) begin
      w = winner(req_valid, m_ptr);
      if (w >= 0) er[w] = 1'b1;
    end
    if (rst_n && m_phase == 2) ev[m_owner] = 1'b1;
    chk("req_ready", {6'd0, req_ready}, {6'd0, er});
    chk("resp_valid", {6'd0, resp_valid}, {6'd0, ev});
    if (m_known) begin
      chk("resp_data", {4'd0, resp_data}, {4'd0, m_res});
      chk("last_res", {4'd0, last_res}, {4'd0, m_last});
      chk("op_count", op_count, m_cnt);
      chk("alu_a", {4'd0, alu_a}, {4'd0, m_a});
      chk("alu_b", {4'd0, alu_b}, {4'd0, m_b});
      chk("alu_op", {5'd0, alu_op}, {5'd0, m_op});
    end
    acc = 2'b00;
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_owner = 0; m_known = 1'b1;
      m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_last = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      if (w >= 0) begin
        acc[w]  = 1'b1;
        m_owner = w;
        m_ptr   = 1 - w;
        m_a     = req_a[w*4 +: 4];
        m_b     = req_b[w*4 +: 4];
        m_op    = req_op[w*3 +: 3];
        m_pend  = alu_f(m_a, m_b, m_op);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_res   = m_pend;
      m_last  = m_pend;
      m_cnt   = m_cnt + 8'd1;
      m_phase = 2;
    end else if (resp_ready[m_owner]) begin
      m_phase = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int   q_g[$];
    int   q_r[$];
    int   fgrants;
    logic [3:0] held;

    m_known = 1'b0; m_phase = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
    rst_n = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0; req_op = '0;
    resp_ready = 2'b00;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_fx_alu_a", {4'd0, f_alu_a}, 8'd0);
    chk("rst_fx_op_count", f_op_count, 8'd0);
    chk("rst_fx_last_res", {4'd0, f_last_res}, 8'd0);

    // 1: single request from requester 0.
    set_cmd(0, 4'd3, 4'd4, 3'd0);
    resp_ready = 2'b11;
    #1 chk("t1_ready", {6'd0, req_ready}, 8'h01);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t1_resp_valid", {6'd0, resp_valid}, 8'h01);
    chk("t1_resp_data", {4'd0, resp_data}, 8'h07);
    chk("t1_op_count", op_count, 8'd1);
    tick();

    // 2: requester 1, subtraction with borrow discarded.
    set_cmd(1, 4'd2, 4'd5, 3'd1);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t2_resp_valid", {6'd0, resp_valid}, 8'h02);
    chk("t2_resp_data", {4'd0, resp_data}, 8'h0d);
    chk("t2_last_res", {4'd0, last_res}, 8'h0d);
    tick();

    // 3: both requesters valid every cycle under round-robin.
    set_cmd(0, 4'd1, 4'd1, 3'd3);
    set_cmd(1, 4'd6, 4'd3, 3'd4);
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready == 2'b01) q_g.push_back(0);
      else if (req_ready == 2'b10) q_g.push_back(1);
      if (resp_valid != 2'b00) q_r.push_back(int'(resp_data));
      tick();
    end
    req_valid = 2'b00;
    chk("t3_ngrants", 8'(q_g.size()), 8'd4);
    chk("t3_nresults", 8'(q_r.size()), 8'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t3_grant", (k < q_g.size()) ? 8'(q_g[k]) : 8'hff, 8'(k % 2));
      chk("t3_result", (k < q_r.size()) ? 8'(q_r[k]) : 8'hff, (k % 2 == 0) ? 8'd1 : 8'd7);
    end

    // 4: fixed priority starves requester 1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_cmd(0, 4'd1, 4'd1, 3'd3);
    set_cmd(1, 4'd6, 4'd3, 3'd4);
    fgrants = 0;
    for (int c = 0; c < 9; c++) begin
      #1;
      chk("t4_fx_ready1", {7'd0, f_req_ready[1]}, 8'd0);
      chk("t4_fx_resp_valid1", {7'd0, f_resp_valid[1]}, 8'd0);
      if (f_req_ready != 2'b00) fgrants++;
      tick();
    end
    req_valid = 2'b00;
    chk("t4_fx_grants", 8'(fgrants), 8'd3);
    chk("t4_fx_op_count", f_op_count, 8'd3);
    chk("t4_fx_last_res", {4'd0, f_last_res}, 8'd1);
    while (m_phase != 0) tick();

    // 5: result held back by the requester while the other one waits.
    resp_ready = 2'b00;
    set_cmd(0, 4'd5, 4'd3, 3'd1);
    tick();
    req_valid = 2'b00;
    set_cmd(1, 4'd7, 4'd7, 3'd7);
    tick();
    held = resp_data;
    chk("t5_data", {4'd0, held}, 8'd2);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t5_hold_valid", {6'd0, resp_valid}, 8'h01);
      chk("t5_hold_ready", {6'd0, req_ready}, 8'h00);
      chk("t5_hold_data", {4'd0, resp_data}, {4'd0, held});
      tick();
    end
    resp_ready = 2'b11;
    tick();
    #1 chk("t5_accept_after", {6'd0, req_ready}, 8'h02);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t5_eq_result", {4'd0, resp_data}, 8'd1);
    tick();

    // 6: reset during the ALU cycle, then a clean op, then wrap op_count.
    set_cmd(0, 4'd9, 4'd9, 3'd0);
    tick();
    req_valid = 2'b00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_op_count", op_count, 8'd0);
    chk("t6_resp_valid", {6'd0, resp_valid}, 8'd0);
    chk("t6_alu_a", {4'd0, alu_a}, 8'd0);
    tick();
    tick();
    set_cmd(0, 4'd1, 4'd2, 3'd0);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t6_clean_data", {4'd0, resp_data}, 8'd3);
    chk("t6_clean_count", op_count, 8'd1);
    tick();
    for (int k = 0; k < 255; k++) begin
      set_cmd(0, 4'($urandom_range(15)), 4'($urandom_range(15)), 3'($urandom_range(7)));
      tick();
      req_valid = 2'b00;
      tick();
      tick();
    end
    chk("t6_wrap", op_count, 8'd0);

    // Random traffic: commands held until taken, occasional withdrawal, random back-pressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && $urandom_range(1) == 1)
          set_cmd(i, 4'($urandom_range(15)), 4'($urandom_range(15)), 3'($urandom_range(7)));
        else if (req_valid[i] && $urandom_range(7) == 0)
          req_valid[i] = 1'b0;
      end
      resp_ready = 2'($urandom_range(3));
      tick();
      for (int i = 0; i < 2; i++) if (acc[i]) req_valid[i] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
